// File: rtl/rs_gf_pkg.sv
// Shared GF(2^M) arithmetic for the Reed-Solomon datapath: FSM state type,
// default primitive polynomials and a polynomial-basis multiply helper.
package rs_gf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gf_state_e;

    // Default primitive polynomials for the widths the decoder uses.
    localparam logic [6:0] GF_POLY_M6 = 7'h73;   // x^6+x^5+x^4+x+1
    localparam logic [8:0] GF_POLY_M8 = 9'h11D;  // x^8+x^4+x^3+x^2+1

    // Shift-and-add multiply with on-the-fly reduction. Sized for the widest
    // legal field (M=12); m and poly must be elaboration constants.
    function automatic logic [11:0] gf_mul(input logic [11:0] a,
                                           input logic [11:0] b,
                                           input int          m,
                                           input logic [12:0] poly);
        logic [12:0] aa;
        logic [12:0] top;
        logic [11:0] bb;
        logic [11:0] p;
        aa  = {1'b0, a};
        bb  = b;
        p   = '0;
        top = 13'd1 << m;
        for (int i = 0; i < 12; i++) begin
            if (i < m) begin
                if (bb[0]) p ^= aa[11:0];
                bb = bb >> 1;
                aa = aa << 1;
                if ((aa & top) != '0) aa ^= poly;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rs_gf_mul.sv
// Combinational GF(2^M) multiplier, polynomial basis, reduced modulo POLY.
// Used both as a squarer (A == B) and as a general multiplier.
module rs_gf_mul
    import rs_gf_pkg::*;
#(
    parameter int         M    = 6,
    parameter logic [M:0] POLY = GF_POLY_M6
) (
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    output logic [M-1:0] P
);

    assign P = M'(gf_mul(12'(A), 12'(B), M, 13'(POLY)));

endmodule

// File: rtl/rs_gf_inv_seq.sv
// Sequential GF(2^M) inverter: R = B^(2^M-2) computed as the product
// B^2 * B^4 * ... * B^(2^(M-1)), one square-and-multiply per enabled cycle.
// Valid/ready on both sides; a DONE result can hand off to the next operand
// in the same edge so a streaming source sees no bubble.
module rs_gf_inv_seq
    import rs_gf_pkg::*;
#(
    parameter int         M    = 6,
    parameter logic [M:0] POLY = GF_POLY_M6
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         enable,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] R,
    output logic         R_zero,
    output logic         busy
);

    localparam int CW = $clog2(M);

    gf_state_e      state_q, state_d;
    logic [M-1:0]   sq_q, sq_d;
    logic [M-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           zflag_q, zflag_d;
    logic [M-1:0]   r_q, r_d;
    logic           rz_q, rz_d;
    logic           ov_q, ov_d;

    logic [M-1:0]   sq2;
    logic [M-1:0]   prod;

    // t = sq^2, then acc*t for the running product
    rs_gf_mul #(.M(M), .POLY(POLY)) u_sqr (.A(sq_q),  .B(sq_q), .P(sq2));
    rs_gf_mul #(.M(M), .POLY(POLY)) u_mul (.A(acc_q), .B(sq2),  .P(prod));

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign busy      = (state_q == CALC);
    assign out_valid = ov_q;
    assign R         = r_q;
    assign R_zero    = rz_q;

    // Next-state: load on accept, square-and-multiply in CALC, hand off in DONE
    always_comb begin
        state_d = state_q;
        sq_d    = sq_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        zflag_d = zflag_q;
        r_d     = r_q;
        rz_d    = rz_q;
        ov_d    = ov_q;

        // Accepting a new operand looks the same from IDLE or DONE.
        if (in_valid && in_ready) begin
            sq_d    = B;
            acc_d   = M'(1);
            cnt_d   = CW'(M - 1);
            zflag_d = (B == '0);
            state_d = CALC;
            ov_d    = 1'b0;
        end else begin
            unique case (state_q)
                CALC: begin
                    sq_d  = sq2;
                    acc_d = prod;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                        r_d     = prod;
                        rz_d    = zflag_q;
                        ov_d    = 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        ov_d    = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers; everything freezes while enable is low
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            sq_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            zflag_q <= 1'b0;
            r_q     <= '0;
            rz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else if (enable) begin
            state_q <= state_d;
            sq_q    <= sq_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            zflag_q <= zflag_d;
            r_q     <= r_d;
            rz_q    <= rz_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_rs_gf_inv_seq.sv
// Directed bench for rs_gf_inv_seq: M=6 default field plus an M=8 instance.
module tb_rs_gf_inv_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;

    logic       iv6, ir6, ov6, or6, rz6, busy6;
    logic [5:0] b6, r6;
    logic       iv8, ir8, ov8, or8, rz8, busy8;
    logic [7:0] b8, r8;

    int n_chk  = 0;
    int n_pass = 0;
    int lat, i, r, n, idle, started, take;
    int unsigned exp_r;
    int unsigned ops[$];

    always #5 clk = ~clk;

    rs_gf_inv_seq #(.M(6), .POLY(7'h73)) d6 (
        .CLK(clk), .RESET(rst_n), .enable(en),
        .in_valid(iv6), .in_ready(ir6), .B(b6),
        .out_valid(ov6), .out_ready(or6), .R(r6), .R_zero(rz6), .busy(busy6)
    );

    rs_gf_inv_seq #(.M(8), .POLY(9'h11D)) d8 (
        .CLK(clk), .RESET(rst_n), .enable(en),
        .in_valid(iv8), .in_ready(ir8), .B(b8),
        .out_valid(ov8), .out_ready(or8), .R(r8), .R_zero(rz8), .busy(busy8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // MSB-first (Horner) GF multiply, independent of the RTL's shift-and-add
    function automatic int unsigned bmul(int unsigned a, int unsigned b, int m, int unsigned poly);
        int unsigned p = 0;
        for (int k = m - 1; k >= 0; k--) begin
            p = p << 1;
            if (((p >> m) & 1) != 0) p ^= poly;
            if (((b >> k) & 1) != 0) p ^= a;
        end
        return p;
    endfunction

    function automatic int unsigned binv(int unsigned a, int m, int unsigned poly);
        for (int x = 1; x < (1 << m); x++)
            if (bmul(a, x, m, poly) == 1) return x;
        return 0;
    endfunction

    task automatic send6(input logic [5:0] b);
        int k = 0;
        @(negedge clk);
        b6 = b; iv6 = 1'b1;
        while (!ir6 && k < 50) begin @(negedge clk); k++; end
        chk("send6_ready", ir6, 1);
        @(posedge clk); #1;
        iv6 = 1'b0;
    endtask

    task automatic wait6(output int l);
        l = 0;
        while (!ov6 && l < 100) begin @(posedge clk); #1; l++; end
        chk("wait6_timeout", ov6, 1);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1;
        iv6 = 0; or6 = 1; b6 = '0;
        iv8 = 0; or8 = 1; b8 = '0;

        // reset state
        #12;
        chk("rst_ov", ov6, 0);
        chk("rst_r", r6, 0);
        chk("rst_rz", rz6, 0);
        chk("rst_ir", ir6, 1);
        chk("rst_busy", busy6, 0);
        chk("rst_ov8", ov8, 0);
        @(negedge clk); rst_n = 1'b1;

        // enable low: no handshake
        en = 1'b0; b6 = 6'd9; iv6 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("en0_busy", busy6, 0);
        chk("en0_ir", ir6, 1);
        iv6 = 1'b0; en = 1'b1;

        // test 1: directed values with latency
        send6(6'd2); wait6(lat);
        chk("t1_lat", lat, 5);
        chk("t1_r2", r6, 57);
        chk("t1_rz2", rz6, 0);
        @(posedge clk); #1;
        chk("t1_idle_ov", ov6, 0);
        send6(6'd63); wait6(lat);
        chk("t1_r63", r6, 20);
        @(posedge clk); #1;
        send6(6'd1); wait6(lat);
        chk("t1_r1", r6, 1);
        @(posedge clk); #1;

        // test 2: exhaustive stream, back-to-back
        i = 0; r = 0; n = 0; idle = 0; started = 0;
        @(negedge clk); b6 = 6'd0; iv6 = 1'b1; or6 = 1'b1;
        while (r < 64 && n < 2000) begin
            take = int'(iv6 && ir6 && en);
            if (ov6) begin
                exp_r = (r == 0) ? 0 : binv(r, 6, 'h73);
                chk("t2_inv", r6, exp_r);
                chk("t2_rz", rz6, (r == 0) ? 1 : 0);
                if (r != 0) chk("t2_prod", bmul(r, r6, 6, 'h73), 1);
                r++;
            end
            if (started != 0 && !busy6 && !ov6) idle++;
            @(posedge clk); #1; n++;
            if (take != 0) begin
                started = 1; i++;
                if (i < 64) b6 = 6'(i); else iv6 = 1'b0;
            end
            @(negedge clk);
        end
        chk("t2_count", r, 64);
        chk("t2_no_bubble", idle, 0);
        @(posedge clk); #1;

        // test 3: backpressure
        or6 = 1'b0;
        send6(6'd4); wait6(lat);
        for (int k = 0; k < 10; k++) begin
            chk("t3_ov", ov6, 1);
            chk("t3_r", r6, 37);
            chk("t3_ir", ir6, 0);
            @(posedge clk); #1;
        end
        or6 = 1'b1;
        @(posedge clk); #1;
        chk("t3_rel_ov", ov6, 0);
        chk("t3_rel_ir", ir6, 1);
        chk("t3_rel_busy", busy6, 0);

        // test 4: enable toggling doubles latency
        send6(6'd3);
        lat = 0;
        while (!ov6 && lat < 100) begin
            en = lat[0];
            @(posedge clk); #1; lat++;
        end
        chk("t4_lat", lat, 10);
        chk("t4_r", r6, 46);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_hold_ov", ov6, 1);
        chk("t4_hold_r", r6, 46);
        en = 1'b1;
        @(posedge clk); #1;
        chk("t4_idle_ov", ov6, 0);

        // test 5: reset mid-calculation
        send6(6'd5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_busy", busy6, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_ov", ov6, 0);
        chk("t5_r", r6, 0);
        chk("t5_ir", ir6, 1);
        chk("t5_busy0", busy6, 0);
        @(negedge clk); rst_n = 1'b1;
        send6(6'd5); wait6(lat);
        chk("t5_r5", r6, 26);
        @(posedge clk); #1;

        // test 6: M=8 field
        @(negedge clk); b8 = 8'h02; iv8 = 1'b1;
        @(posedge clk); #1; iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("t6_lat", lat, 7);
        chk("t6_r", r8, 8'h8E);
        chk("t6_rz", rz8, 0);
        @(posedge clk); #1;

        i = 0; r = 0; n = 0;
        @(negedge clk);
        ops.push_back($urandom_range(255, 1));
        b8 = 8'(ops[0]); iv8 = 1'b1;
        while (r < 1000 && n < 20000) begin
            take = int'(iv8 && ir8 && en);
            if (ov8) begin
                chk("t6_prod", bmul(ops[r], r8, 8, 'h11D), 1);
                chk("t6_rzr", rz8, 0);
                r++;
            end
            @(posedge clk); #1; n++;
            if (take != 0) begin
                i++;
                if (i < 1000) begin
                    ops.push_back($urandom_range(255, 1));
                    b8 = 8'(ops[i]);
                end else iv8 = 1'b0;
            end
            @(negedge clk);
        end
        chk("t6_count", r, 1000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
